// File: rtl/panel_control.sv
// Front-panel controller: debounces four active-low keys, keeps the live algorithm/zoom
// selection and issues one START/BUSY command at a time with the selection locked.
module panel_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_key,
  input  logic       i_busy,
  output logic [1:0] o_algorithm,
  output logic [1:0] o_zoom_level,
  output logic [1:0] o_cmd_algorithm,
  output logic [1:0] o_cmd_zoom,
  output logic       o_start,
  output logic       o_done,
  output logic       o_error,
  output logic       o_locked
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  // state | meaning: IDLE selectable | ISSUE START strobe | WAIT_ACK await BUSY high | RUN await BUSY low
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_RUN} state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_d;
  logic [DW-1:0] r_db_cnt [4];
  logic [3:0]    w_press;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_deb   <= 4'hF;
      r_deb_d <= 4'hF;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_deb[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_ONE;
        end
      end
    end
  end

  // Press = debounced falling edge, valid for exactly one cycle.
  assign w_press = r_deb_d & ~r_deb;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_alg,       w_alg_next;
  logic [1:0]    r_zoom,      w_zoom_next;
  logic [1:0]    r_cmd_alg,   w_cmd_alg_next;
  logic [1:0]    r_cmd_zoom,  w_cmd_zoom_next;
  logic          r_start,     w_start_next;
  logic          r_done,      w_done_next;
  logic          r_error,     w_error_next;
  logic [TW-1:0] r_to_cnt,    w_to_cnt_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_alg      <= 2'd0;
      r_zoom     <= 2'd0;
      r_cmd_alg  <= 2'd0;
      r_cmd_zoom <= 2'd0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_alg      <= w_alg_next;
      r_zoom     <= w_zoom_next;
      r_cmd_alg  <= w_cmd_alg_next;
      r_cmd_zoom <= w_cmd_zoom_next;
      r_start    <= w_start_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_to_cnt   <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_alg_next      = r_alg;
    w_zoom_next     = r_zoom;
    w_cmd_alg_next  = r_cmd_alg;
    w_cmd_zoom_next = r_cmd_zoom;
    w_start_next    = 1'b0;
    w_done_next     = 1'b0;
    w_error_next    = r_error;
    w_to_cnt_next   = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_press[3]) begin
          w_cmd_alg_next  = r_alg;
          w_cmd_zoom_next = r_zoom;
          w_start_next    = 1'b1;
          w_error_next    = 1'b0;
          w_state_next    = S_ISSUE;
        end else begin
          if (w_press[0] && !w_press[1] && r_zoom != 2'd3) w_zoom_next = r_zoom + 2'd1;
          else if (w_press[1] && !w_press[0] && r_zoom != 2'd0) w_zoom_next = r_zoom - 2'd1;
          if (w_press[2]) w_alg_next = r_alg + 2'd1;
        end
      end
      S_ISSUE: begin
        w_to_cnt_next = '0;
        w_state_next  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (i_busy) begin
          w_state_next = S_RUN;
        end else if (r_to_cnt == TO_LAST) begin
          w_error_next  = 1'b1;
          w_to_cnt_next = '0;
          w_state_next  = S_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_ONE;
        end
      end
      S_RUN: begin
        if (!i_busy) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_algorithm     = r_alg;
  assign o_zoom_level    = r_zoom;
  assign o_cmd_algorithm = r_cmd_alg;
  assign o_cmd_zoom      = r_cmd_zoom;
  assign o_start         = r_start;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_locked        = (r_state != S_IDLE);

endmodule

// File: tb/tb_panel_control.sv
// Directed bench for panel_control with DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8.
module tb_panel_control;
  localparam int DB = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic       busy = 1'b0;
  logic [1:0] o_algorithm, o_zoom_level, o_cmd_algorithm, o_cmd_zoom;
  logic       o_start, o_done, o_error, o_locked;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  panel_control #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_key(key), .i_busy(busy),
    .o_algorithm(o_algorithm), .o_zoom_level(o_zoom_level),
    .o_cmd_algorithm(o_cmd_algorithm), .o_cmd_zoom(o_cmd_zoom),
    .o_start(o_start), .o_done(o_done), .o_error(o_error), .o_locked(o_locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int hold);
    key[k] = 1'b0;
    repeat (hold) tick();
    key[k] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] all;
    rst = 1'b1;
    repeat (2) tick();
    all = {o_algorithm, o_zoom_level, o_cmd_algorithm, o_cmd_zoom, o_start, o_done, o_error, o_locked};
    vec_cnt++;
    if (all !== 12'h000) begin
      err_cnt++; $display("FAIL reset_outputs: got %h expected 000", all);
    end
    rst = 1'b0;
    repeat (3) tick();
    all = {o_algorithm, o_zoom_level, o_cmd_algorithm, o_cmd_zoom, o_start, o_done, o_error, o_locked};
    vec_cnt++;
    if (all !== 12'h000) begin
      err_cnt++; $display("FAIL idle_after_reset: got %h expected 000", all);
    end
  endtask

  task automatic test_zoom();
    int exp_z [9];
    exp_z = '{1, 2, 3, 3, 2, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      press((i < 4) ? 0 : 1, 10);
      vec_cnt++;
      if (o_zoom_level !== 2'(exp_z[i])) begin
        err_cnt++; $display("FAIL zoom_step%0d: got %0d expected %0d", i, o_zoom_level, exp_z[i]);
      end
    end
  endtask

  task automatic test_algorithm();
    for (int i = 0; i < 5; i++) begin
      press(2, 10);
      vec_cnt++;
      if (o_algorithm !== 2'((i + 1) % 4)) begin
        err_cnt++; $display("FAIL alg_step%0d: got %0d expected %0d", i, o_algorithm, (i + 1) % 4);
      end
    end
  endtask

  task automatic test_debounce();
    key[0] = 1'b0;
    repeat (3) tick();
    key[0] = 1'b1;
    repeat (8) tick();
    vec_cnt++;
    if (o_zoom_level !== 2'd0) begin
      err_cnt++; $display("FAIL glitch_ignored: got %0d expected 0", o_zoom_level);
    end
    key[0] = 1'b0;
    repeat (6) tick();
    vec_cnt++;
    if (o_zoom_level !== 2'd0) begin
      err_cnt++; $display("FAIL latency_early: got %0d expected 0", o_zoom_level);
    end
    tick();
    vec_cnt++;
    if (o_zoom_level !== 2'd1) begin
      err_cnt++; $display("FAIL latency_edge6: got %0d expected 1", o_zoom_level);
    end
    key[0] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_command();
    bit found;
    bit done_seen;
    int n;
    press(2, 10);
    vec_cnt++;
    if (o_algorithm !== 2'd2) begin
      err_cnt++; $display("FAIL cmd_pre_alg: got %0d expected 2", o_algorithm);
    end
    busy = 1'b0;
    key[3] = 1'b0;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (o_start === 1'b1) begin found = 1'b1; n = i; end
    end
    vec_cnt++;
    if (!found || n != 7) begin
      err_cnt++; $display("FAIL start_latency: got %0d expected 7", n);
    end
    vec_cnt++;
    if ({o_cmd_algorithm, o_cmd_zoom, o_locked} !== {2'd2, 2'd1, 1'b1}) begin
      err_cnt++; $display("FAIL cmd_latch: got alg %0d zoom %0d locked %b expected 2 1 1",
                          o_cmd_algorithm, o_cmd_zoom, o_locked);
    end
    key[3] = 1'b1;
    busy = 1'b1;
    key[0] = 1'b0;
    tick();
    vec_cnt++;
    if (o_start !== 1'b0) begin
      err_cnt++; $display("FAIL start_width: got %b expected 0", o_start);
    end
    done_seen = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (i == 10) key[0] = 1'b1;
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    vec_cnt++;
    if (done_seen || o_locked !== 1'b1) begin
      err_cnt++; $display("FAIL run_hold: got done %b locked %b expected 0 1", done_seen, o_locked);
    end
    busy = 1'b0;
    tick();
    vec_cnt++;
    if ({o_done, o_locked} !== 2'b10) begin
      err_cnt++; $display("FAIL done_pulse: got done %b locked %b expected 1 0", o_done, o_locked);
    end
    tick();
    vec_cnt++;
    if (o_done !== 1'b0) begin
      err_cnt++; $display("FAIL done_width: got %b expected 0", o_done);
    end
    vec_cnt++;
    if ({o_zoom_level, o_algorithm} !== {2'd1, 2'd2}) begin
      err_cnt++; $display("FAIL locked_drop: got zoom %0d alg %0d expected 1 2", o_zoom_level, o_algorithm);
    end
  endtask

  task automatic test_timeout();
    bit found;
    bit done_seen;
    busy = 1'b0;
    key[3] = 1'b0;
    wait_start(found);
    key[3] = 1'b1;
    vec_cnt++;
    if (!found) begin
      err_cnt++; $display("FAIL to_start: got no start expected start");
    end
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    vec_cnt++;
    if ({o_locked, o_error} !== 2'b10) begin
      err_cnt++; $display("FAIL to_waiting: got locked %b error %b expected 1 0", o_locked, o_error);
    end
    tick();
    if (o_done === 1'b1) done_seen = 1'b1;
    vec_cnt++;
    if ({o_error, o_locked, done_seen} !== 3'b100) begin
      err_cnt++; $display("FAIL to_expire: got error %b locked %b done %b expected 1 0 0",
                          o_error, o_locked, done_seen);
    end
    repeat (4) tick();
    vec_cnt++;
    if (o_error !== 1'b1) begin
      err_cnt++; $display("FAIL error_sticky: got %b expected 1", o_error);
    end
    key[3] = 1'b0;
    wait_start(found);
    key[3] = 1'b1;
    vec_cnt++;
    if (!found || o_error !== 1'b0) begin
      err_cnt++; $display("FAIL error_clear: got start %b error %b expected 1 0", found, o_error);
    end
    for (int i = 0; i < 20 && o_locked === 1'b1; i++) tick();
    vec_cnt++;
    if ({o_locked, o_error} !== 2'b01) begin
      err_cnt++; $display("FAIL to_second: got locked %b error %b expected 0 1", o_locked, o_error);
    end
    repeat (8) tick();
  endtask

  task automatic test_simultaneous();
    bit found;
    bit done_seen;
    key[0] = 1'b0; key[1] = 1'b0;
    repeat (10) tick();
    key = 4'hF;
    repeat (8) tick();
    vec_cnt++;
    if (o_zoom_level !== 2'd1) begin
      err_cnt++; $display("FAIL zoom_in_out: got %0d expected 1", o_zoom_level);
    end
    key[0] = 1'b0; key[2] = 1'b0;
    repeat (10) tick();
    key = 4'hF;
    repeat (8) tick();
    vec_cnt++;
    if ({o_algorithm, o_zoom_level} !== {2'd3, 2'd2}) begin
      err_cnt++; $display("FAIL alg_and_zoom: got alg %0d zoom %0d expected 3 2", o_algorithm, o_zoom_level);
    end
    key[2] = 1'b0; key[3] = 1'b0;
    wait_start(found);
    key = 4'hF;
    vec_cnt++;
    if (!found || {o_cmd_algorithm, o_cmd_zoom} !== {2'd3, 2'd2}) begin
      err_cnt++; $display("FAIL start_with_alg: got start %b cmd_alg %0d cmd_zoom %0d expected 1 3 2",
                          found, o_cmd_algorithm, o_cmd_zoom);
    end
    busy = 1'b1;
    repeat (4) tick();
    busy = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      tick();
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    repeat (8) tick();
    vec_cnt++;
    if (!done_seen || o_algorithm !== 2'd3 || o_error !== 1'b0) begin
      err_cnt++; $display("FAIL alg_dropped: got done %b alg %0d error %b expected 1 3 0",
                          done_seen, o_algorithm, o_error);
    end
  endtask

  task automatic test_reset_in_run();
    bit found;
    bit done_seen;
    logic [11:0] all;
    key[3] = 1'b0;
    wait_start(found);
    key[3] = 1'b1;
    busy = 1'b1;
    repeat (3) tick();
    vec_cnt++;
    if (!found || o_locked !== 1'b1) begin
      err_cnt++; $display("FAIL run_entered: got start %b locked %b expected 1 1", found, o_locked);
    end
    #2 rst = 1'b1;
    #1;
    all = {o_algorithm, o_zoom_level, o_cmd_algorithm, o_cmd_zoom, o_start, o_done, o_error, o_locked};
    vec_cnt++;
    if (all !== 12'h000) begin
      err_cnt++; $display("FAIL async_reset: got %h expected 000", all);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    busy = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    vec_cnt++;
    if ({done_seen, o_locked, o_start} !== 3'b000) begin
      err_cnt++; $display("FAIL post_reset_idle: got done %b locked %b start %b expected 0 0 0",
                          done_seen, o_locked, o_start);
    end
  endtask

  initial begin
    test_reset();
    test_zoom();
    test_algorithm();
    test_debounce();
    test_command();
    test_timeout();
    test_simultaneous();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/panel_control.md
# panel_control

Front-panel input controller for the coprocessor board. It synchronizes and debounces the four active-low pushbuttons and maintains the live algorithm and zoom selection shown on the seven-segment display. On request, it issues a single command to the scaling coprocessor through a START/BUSY handshake and holds the selection locked until the command completes.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a key level is accepted (min 2).
- ACK_TIMEOUT, 255: maximum cycles to wait for BUSY to rise after START (min 1).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- KEY  in  4  raw pushbuttons, active-low; KEY[0] zoom in, KEY[1] zoom out, KEY[2] next algorithm, KEY[3] start.
- BUSY  in  1  coprocessor busy, synchronous to CLK.
- ALGORITHM  out  2  live selection: 0 NN, 1 PR, 2 DC, 3 BA.
- ZOOM_LEVEL  out  2  live selection: 0 1x, 1 2x, 2 4x, 3 8x.
- CMD_ALGORITHM  out  2  algorithm latched at command issue.
- CMD_ZOOM  out  2  zoom latched at command issue.
- START  out  1  one-cycle command strobe.
- DONE  out  1  one-cycle pulse when the command completes.
- ERROR  out  1  sticky flag, set on handshake timeout.
- LOCKED  out  1  high whenever the FSM is not in IDLE.

## Operation

- Reset values: ALGORITHM=0, ZOOM_LEVEL=0, CMD_ALGORITHM=0, CMD_ZOOM=0, START=0, DONE=0, ERROR=0, LOCKED=0. Both synchronizer flops and the debounced state of every key reset to 1 (released). Debounce counters and the timeout counter reset to 0. FSM resets to IDLE.
- Per key: 2-flop synchronizer, then debouncer. The counter increments while the synchronized level differs from the debounced state. It clears to 0 when the levels match. When the count reaches DEBOUNCE_CYCLES, the debounced state takes the new level and the counter clears.
- A press event is a debounced 1->0 transition and lasts one cycle. Releases generate no events.
- In IDLE only:
  - Zoom in: ZOOM_LEVEL+1, saturating at 3.
  - Zoom out: ZOOM_LEVEL-1, saturating at 0.
  - Zoom in and zoom out in the same cycle: no change.
  - Algorithm press: ALGORITHM+1 mod 4; 3 wraps to 0.
  - Algorithm and zoom presses in the same cycle: both apply.
- Start press in IDLE: CMD_ALGORITHM and CMD_ZOOM latch the current ALGORITHM and ZOOM_LEVEL; START=1; ERROR clears; FSM goes to ISSUE. Selection presses in the same cycle are dropped.
- FSM states:
  - IDLE -> ISSUE on a start press.
  - ISSUE: START is high for this one cycle; timeout counter clears; -> WAIT_ACK.
  - WAIT_ACK: if BUSY=1, -> RUN. Otherwise the counter increments. When the counter reaches ACK_TIMEOUT, ERROR=1 and -> IDLE, with no DONE pulse.
  - RUN: when BUSY=0, DONE=1 for one cycle and -> IDLE.
- Outside IDLE, all key press events are discarded, not queued. Debouncing continues in every state.
- RESET asserted mid-command returns all outputs and state to reset values immediately. No DONE is emitted.

## Timing

- Raw KEY low and steady from before edge E: synchronized level is low after E+1; debounced state is low after E+1+DEBOUNCE_CYCLES; selection updates (or START asserts) after E+2+DEBOUNCE_CYCLES.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles restarts the count and produces no event.
- START is registered and asserts in the cycle after the start press event. CMD_* are valid from the START cycle onward and stay stable until the next START.
- BUSY is sampled from the first WAIT_ACK cycle. BUSY already high at that point moves the FSM to RUN after one edge.
- DONE asserts in the cycle after BUSY is sampled low in RUN. LOCKED falls in the same cycle that DONE is high. A new press is accepted from the following cycle.
- LOCKED rises in the START cycle.

## Test plan

DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8.
- Reset, then three KEY[0] presses, each held 10 cycles -> ZOOM_LEVEL 1, 2, 3. A fourth press -> stays 3. Five KEY[1] presses -> 0 and stays 0.
- KEY[2] pressed five times -> ALGORITHM 1, 2, 3, 0, 1. A KEY[0] glitch low for 3 cycles -> no change. Held 4+ cycles -> update exactly 6 edges after the first low sample.
- ALGORITHM=2, ZOOM_LEVEL=1, press KEY[3] -> START high for exactly 1 cycle, CMD_ALGORITHM=2, CMD_ZOOM=1. BUSY high for 20 cycles -> DONE pulses 1 cycle after BUSY falls. KEY[0] pressed during RUN -> ZOOM_LEVEL remains 1.
- Start press with BUSY held 0 -> ERROR=1 and LOCKED=0 after 8 WAIT_ACK cycles, no DONE. Next start press -> ERROR clears in the START cycle.
- KEY[0] and KEY[1] debounced in the same cycle -> ZOOM_LEVEL unchanged. KEY[2] and KEY[3] together -> command carries the old ALGORITHM; ALGORITHM is unchanged afterwards.
- RESET pulsed while in RUN -> all outputs 0 asynchronously. After release, FSM is in IDLE and BUSY falling produces no DONE.
